instruction_memory_responder: RTL and testbench
===============================================

# instruction_memory_responder

Backing-memory responder for the instruction cache's block-fill path: it accepts a block request from the cache, waits a fixed access latency, then streams the block one word per cycle. It is the memory end of the cache's miss interface and stands in for main memory in simulation and small builds. A preload port lets benches and boot logic fill the word array.

## Interface

Parameters:
- WORD_WIDTH, 32, bits per word.
- BLOCK_WORDS, 4, words per cache block; power of two, 1..16.
- MEM_WORDS, 1024, array depth in words; power of two.
- LATENCY, 3, idle cycles between request acceptance and first word; 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- reqValid  in  1  cache requests a block.
- reqBlockAddr  in  32  byte address; low 2 + log2(BLOCK_WORDS) bits are ignored.
- reqReady  out  1  high only in IDLE.
- respValid  out  1  respData holds a valid word.
- respReady  in  1  cache takes the word this cycle.
- respData  out  WORD_WIDTH  streamed word.
- respWordIndex  out  log2(BLOCK_WORDS)  word offset within block, 0 first.
- respLast  out  1  high with the final word of the block.
- busy  out  1  high in any state other than IDLE.
- loadEnable  in  1  preload write strobe.
- loadAddr  in  32  word address for preload, taken modulo MEM_WORDS.
- loadData  in  WORD_WIDTH  preload data.

## Operation

- States: IDLE, WAIT, BURST.
- IDLE: reqReady=1. On reqValid, latch block base = (reqBlockAddr >> 2) with the low log2(BLOCK_WORDS) bits cleared, modulo MEM_WORDS. Go to WAIT if LATENCY>0, otherwise BURST. Load the latency counter with LATENCY.
- WAIT: the counter decrements each cycle. At 1 it goes to BURST. reqValid is ignored.
- BURST: respValid=1. respData = mem[base + index]; the array is read combinationally at stream time, not captured at acceptance. A transfer occurs when respValid && respReady; on transfer the index increments. On transfer with index = BLOCK_WORDS-1 (respLast=1), return to IDLE. When respReady=0, respData, respWordIndex and respLast hold.
- Address arithmetic: base + index never crosses a block boundary, since the base is aligned. Addresses beyond MEM_WORDS wrap modulo MEM_WORDS.
- Preload: accepted on any cycle and in any state. A write to a word not yet transferred in the active burst is visible when that word streams. A write to the word currently presented updates respData in the next cycle.
- Requests arriving outside IDLE are not queued. The cache must hold reqValid until it sees reqReady.

## Timing

- Reset values: reqReady=1, respValid=0, respData=0, respWordIndex=0, respLast=0, busy=0, state=IDLE, counter=0. Reset is asynchronous: asserting it mid-WAIT or mid-BURST clears the outputs immediately.
- Reset does not clear array contents. Array contents are undefined until preloaded.
- Acceptance edge T0: busy=1 and reqReady=0 from T0 onward.
- First word: respValid rises after edge T0+LATENCY (LATENCY=0 gives respValid right after T0).
- Full-rate burst with respReady held high: BLOCK_WORDS consecutive valid cycles. After the respLast transfer edge, reqReady=1 and busy=0 in the next cycle.
- Minimum request-to-request spacing is LATENCY + BLOCK_WORDS + 1 cycles. There is no same-cycle turnaround.
- respValid never drops within a burst.

## Structure

- Shared package / include alongside Utility.v: WORD_WIDTH and BLOCK_WORDS. The block size must equal the instruction cache's words-per-block constant.
- State encodings IDLE/WAIT/BURST also go in the shared include.
- Sub-module word_memory_array: MEM_WORDS × WORD_WIDTH, one synchronous write port (load) and one combinational read port. The FSM, counter and index registers stay in the top module.

## Test plan

- Preload mem[0..7] = 0xA0..0xA7; request byte address 0x00 with LATENCY=3 and respReady=1 -> respValid first after edge T0+3. Words 0xA0..0xA3 with indices 0..3. respLast on 0xA3. reqReady high the next cycle.
- Request byte address 0x1C -> base word 4; words 0xA4..0xA7 stream, confirming low-bit masking.
- Stall: respReady low for 2 cycles at index 1 -> respData holds 0xA1 and respWordIndex holds 1; the burst resumes and completes with 4 transfers total.
- Reset asserted mid-BURST at index 2 -> outputs are at reset values immediately. A new request to 0x00 then returns 0xA0..0xA3, showing memory contents preserved.
- Request byte address 4·MEM_WORDS + 0x10 -> wraps to word 4, returning 0xA4..0xA7. A reqValid pulse during WAIT is ignored, so no second burst follows.
- Preload mem[3]=0xFF during WAIT of a request to 0x00 -> the streamed word 3 is 0xFF. Re-run with LATENCY=0 -> first word valid right after the acceptance edge.

Source files
------------

// File: rtl/instruction_memory_responder_pkg.sv
// Shared constants and state encoding for the instruction-cache block-fill responder.
package instruction_memory_responder_pkg;

    // Must match the instruction cache's word width and words-per-block constant.
    localparam int CACHE_WORD_WIDTH  = 32;
    localparam int CACHE_BLOCK_WORDS = 4;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_WAIT  = 2'd1,
        STATE_BURST = 2'd2
    } respState_t;

    // Word-index width; a one-word block still needs a one-bit port.
    function automatic int indexWidth(input int blockWords);
        return (blockWords > 1) ? $clog2(blockWords) : 1;
    endfunction

endpackage

// File: rtl/instruction_memory_responder_word_memory_array.sv
// Word array: one synchronous write port (preload) and one combinational read port.
module instruction_memory_responder_word_memory_array #(
    parameter int WORD_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    localparam int ADDR_WIDTH = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [WORD_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    output logic [WORD_WIDTH-1:0] readData
);

    logic [WORD_WIDTH-1:0] mem [MEM_WORDS];

    // Preload write; the array has no reset so contents survive a responder reset.
    // NOTE: memories are deliberately left out of reset; resetting them would force flops instead of RAM.
    always_ff @(posedge clk) begin
        if (writeEnable) begin
            mem[writeAddr] <= writeData;
        end
    end

    assign readData = mem[readAddr];

endmodule

// File: rtl/instruction_memory_responder.sv
// Memory end of the instruction cache miss interface: accept a block request,
// wait LATENCY cycles, then stream the block one word per accepted transfer.
module instruction_memory_responder
    import instruction_memory_responder_pkg::*;
#(
    parameter int WORD_WIDTH  = CACHE_WORD_WIDTH,
    parameter int BLOCK_WORDS = CACHE_BLOCK_WORDS,
    parameter int MEM_WORDS   = 1024,
    parameter int LATENCY     = 3,
    localparam int INDEX_WIDTH = indexWidth(BLOCK_WORDS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reqValid,
    input  logic [31:0]            reqBlockAddr,
    output logic                   reqReady,
    output logic                   respValid,
    input  logic                   respReady,
    output logic [WORD_WIDTH-1:0]  respData,
    output logic [INDEX_WIDTH-1:0] respWordIndex,
    output logic                   respLast,
    output logic                   busy,
    input  logic                   loadEnable,
    input  logic [31:0]            loadAddr,
    input  logic [WORD_WIDTH-1:0]  loadData
);

    localparam int ADDR_WIDTH = $clog2(MEM_WORDS);
    localparam logic [3:0] LATENCY_LOAD = 4'(LATENCY);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(BLOCK_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BLOCK_WORDS - 1);

    respState_t             state, stateNext;
    logic [3:0]             latencyCount, latencyCountNext;
    logic [ADDR_WIDTH-1:0]  blockBase, blockBaseNext;
    logic [INDEX_WIDTH-1:0] wordIndex, wordIndexNext;
    logic [ADDR_WIDTH-1:0]  requestWord;
    logic [ADDR_WIDTH-1:0]  readAddr;
    logic [WORD_WIDTH-1:0]  readData;
    logic                   unusedAddrBits;

    // Byte address to word address, modulo the array depth.
    assign requestWord = reqBlockAddr[ADDR_WIDTH+1:2];
    // The base is block-aligned, so the offset never carries into the next block.
    assign readAddr    = blockBase + ADDR_WIDTH'(wordIndex);
    assign unusedAddrBits = ^{reqBlockAddr[31:ADDR_WIDTH+2], reqBlockAddr[1:0], loadAddr[31:ADDR_WIDTH]};

    instruction_memory_responder_word_memory_array #(
        .WORD_WIDTH (WORD_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) wordMemory (
        .clk         (clk),
        .writeEnable (loadEnable),
        .writeAddr   (loadAddr[ADDR_WIDTH-1:0]),
        .writeData   (loadData),
        .readAddr    (readAddr),
        .readData    (readData)
    );

    // State, latency counter, block base and word index registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= STATE_IDLE;
            latencyCount <= '0;
            blockBase    <= '0;
            wordIndex    <= '0;
        end else begin
            state        <= stateNext;
            latencyCount <= latencyCountNext;
            blockBase    <= blockBaseNext;
            wordIndex    <= wordIndexNext;
        end
    end

    // Next-state logic and handshake outputs.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext        = state;
        latencyCountNext = latencyCount;
        blockBaseNext    = blockBase;
        wordIndexNext    = wordIndex;
        reqReady         = 1'b0;
        respValid        = 1'b0;
        busy             = 1'b1;
        case (state)
            STATE_IDLE: begin
                reqReady = 1'b1;
                busy     = 1'b0;
                if (reqValid) begin
                    blockBaseNext    = requestWord & ALIGN_MASK;
                    wordIndexNext    = '0;
                    latencyCountNext = LATENCY_LOAD;
                    stateNext        = (LATENCY == 0) ? STATE_BURST : STATE_WAIT;
                end
            end
            STATE_WAIT: begin
                if (latencyCount <= 4'd1) begin
                    latencyCountNext = '0;
                    stateNext        = STATE_BURST;
                end else begin
                    latencyCountNext = latencyCount - 4'd1;
                end
            end
            STATE_BURST: begin
                respValid = 1'b1;
                if (respReady) begin
                    if (wordIndex == LAST_INDEX) begin
                        wordIndexNext = '0;
                        stateNext     = STATE_IDLE;
                    end else begin
                        wordIndexNext = wordIndex + INDEX_WIDTH'(1);
                    end
                end
            end
            default: stateNext = STATE_IDLE;
        endcase
    end

    // Data is read live from the array, so preloads to unsent words show up in the stream.
    assign respData      = respValid ? readData : '0;
    assign respWordIndex = wordIndex;
    assign respLast      = respValid && (wordIndex == LAST_INDEX);

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Self-checking bench: two responders (LATENCY 3 and 0) against an array-based reference model.
module tb_instruction_memory_responder;

    localparam int BW  = 4;
    localparam int MEM = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic [31:0] reqBlockAddr;
    logic        respReady;
    logic        loadEnable;
    logic [31:0] loadAddr;
    logic [31:0] loadData;
    logic        useB;

    logic        reqValidA, reqReadyA, respValidA, respLastA, busyA;
    logic [31:0] respDataA;
    logic [1:0]  respWordIndexA;
    logic        reqValidB, reqReadyB, respValidB, respLastB, busyB;
    logic [31:0] respDataB;
    logic [1:0]  respWordIndexB;

    logic        obsReqReady, obsRespValid, obsRespLast, obsBusy;
    logic [31:0] obsRespData;
    logic [1:0]  obsRespWordIndex;

    logic [31:0] refMem [MEM];
    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    assign reqValidA = reqValid & ~useB;
    assign reqValidB = reqValid & useB;
    assign obsReqReady      = useB ? reqReadyB      : reqReadyA;
    assign obsRespValid     = useB ? respValidB     : respValidA;
    assign obsRespLast      = useB ? respLastB      : respLastA;
    assign obsBusy          = useB ? busyB          : busyA;
    assign obsRespData      = useB ? respDataB      : respDataA;
    assign obsRespWordIndex = useB ? respWordIndexB : respWordIndexA;

    instruction_memory_responder #(.WORD_WIDTH(32), .BLOCK_WORDS(BW), .MEM_WORDS(MEM), .LATENCY(3)) dutA (
        .clk(clk), .reset(reset), .reqValid(reqValidA), .reqBlockAddr(reqBlockAddr),
        .reqReady(reqReadyA), .respValid(respValidA), .respReady(respReady), .respData(respDataA),
        .respWordIndex(respWordIndexA), .respLast(respLastA), .busy(busyA),
        .loadEnable(loadEnable), .loadAddr(loadAddr), .loadData(loadData)
    );

    instruction_memory_responder #(.WORD_WIDTH(32), .BLOCK_WORDS(BW), .MEM_WORDS(MEM), .LATENCY(0)) dutB (
        .clk(clk), .reset(reset), .reqValid(reqValidB), .reqBlockAddr(reqBlockAddr),
        .reqReady(reqReadyB), .respValid(respValidB), .respReady(respReady), .respData(respDataB),
        .respWordIndex(respWordIndexB), .respLast(respLastB), .busy(busyB),
        .loadEnable(loadEnable), .loadAddr(loadAddr), .loadData(loadData)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, ".reqReady"},  obsReqReady, 1);
        check({tag, ".respValid"}, obsRespValid, 0);
        check({tag, ".respData"},  obsRespData, 0);
        check({tag, ".index"},     obsRespWordIndex, 0);
        check({tag, ".respLast"},  obsRespLast, 0);
        check({tag, ".busy"},      obsBusy, 0);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic preload(input int unsigned addr, input logic [31:0] data);
        loadEnable = 1'b1;
        loadAddr   = addr;
        loadData   = data;
        refMem[addr % MEM] = data;
        @(negedge clk);
        loadEnable = 1'b0;
    endtask

    // mode bits: 1 stall two cycles at index 1, 2 random stalls and preloads,
    // 4 reqValid pulse during WAIT, 8 write word 3 of the block to 0xFF during WAIT.
    task automatic runBurst(input logic [31:0] byteAddr, input int mode, input int abortIdx);
        int unsigned base;
        int lat, idx, transfers, cycles, stalled, offset;
        bit done, aborted, ready;
        lat  = useB ? 0 : 3;
        base = (((byteAddr >> 2) / BW) * BW) % MEM;
        check("idleReady", obsReqReady, 1);
        reqValid     = 1'b1;
        reqBlockAddr = byteAddr;
        @(negedge clk);
        reqValid = 1'b0;
        for (int k = 0; k < lat; k++) begin
            loadEnable = 1'b0;
            check("waitValid", obsRespValid, 0);
            check("waitBusy", obsBusy, 1);
            check("waitReady", obsReqReady, 0);
            reqValid = ((mode & 4) != 0) && (k == 0);
            if (((mode & 8) != 0) && (k == 0)) begin
                loadEnable = 1'b1;
                loadAddr   = base + 3;
                loadData   = 32'hFF;
                refMem[(base + 3) % MEM] = 32'hFF;
            end
            @(negedge clk);
        end
        reqValid   = 1'b0;
        idx        = 0;
        transfers  = 0;
        cycles     = 0;
        stalled    = 0;
        done       = 1'b0;
        aborted    = 1'b0;
        while (!done && !aborted && cycles < 64) begin
            loadEnable = 1'b0;
            check("burstValid", obsRespValid, 1);
            check("burstIndex", obsRespWordIndex, idx);
            check("burstData", obsRespData, refMem[(base + idx) % MEM]);
            check("burstLast", obsRespLast, (idx == BW - 1));
            check("burstBusy", obsBusy, 1);
            check("burstReady", obsReqReady, 0);
            if (idx == abortIdx) begin
                reset = 1'b1;
                #1;
                checkResetOutputs("abort");
                @(negedge clk);
                reset   = 1'b0;
                aborted = 1'b1;
            end else begin
                ready = 1'b1;
                if ((mode & 1) != 0 && idx == 1 && stalled < 2) begin
                    ready = 1'b0;
                    stalled++;
                end
                if ((mode & 2) != 0) begin
                    ready = ($urandom_range(0, 2) != 0);
                    if ($urandom_range(0, 2) == 0) begin
                        offset     = $urandom_range(idx, BW - 1);
                        loadEnable = 1'b1;
                        loadAddr   = base + offset + MEM * $urandom_range(0, 3);
                        loadData   = $urandom;
                        refMem[(base + offset) % MEM] = loadData;
                    end
                end
                respReady = ready;
                @(negedge clk);
                cycles++;
                if (ready) begin
                    transfers++;
                    if (idx == BW - 1) done = 1'b1;
                    else idx++;
                end
            end
        end
        respReady  = 1'b1;
        loadEnable = 1'b0;
        if (!aborted) begin
            check("burstDone", done, 1);
            check("transfers", transfers, BW);
            check("postReady", obsReqReady, 1);
            check("postBusy", obsBusy, 0);
            check("postValid", obsRespValid, 0);
            @(negedge clk);
            check("idleValid", obsRespValid, 0);
            check("idleBusy", obsBusy, 0);
        end
    endtask

    initial begin
        logic [31:0] addr;
        reset        = 1'b1;
        reqValid     = 1'b0;
        reqBlockAddr = '0;
        respReady    = 1'b1;
        loadEnable   = 1'b0;
        loadAddr     = '0;
        loadData     = '0;
        useB         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        useB = 1'b1;
        checkResetOutputs("resetB");
        useB  = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) preload(i, 32'hA0 + i);
        for (int i = 8; i < 64; i++) preload(i + MEM * $urandom_range(0, 3), $urandom);

        runBurst(32'h0, 0, -1);
        runBurst(32'h1C, 0, -1);
        runBurst(32'h0, 1, -1);
        runBurst(32'h0, 0, 2);
        runBurst(32'h0, 0, -1);
        runBurst(4 * MEM + 32'h10, 4, -1);
        runBurst(32'h0, 8, -1);

        useB = 1'b1;
        runBurst(32'h0, 0, -1);
        runBurst(32'h1C, 2, -1);

        for (int n = 0; n < 16; n++) begin
            useB = $urandom_range(0, 1);
            addr = $urandom_range(0, 255) + 4 * MEM * $urandom_range(0, 7);
            runBurst(addr, 2 | (4 * $urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
